// File: rtl/grey_sync_decoder.sv
// Consumer end of a gray-coded count crossing: synchronizes gray_in, decodes it to binary,
// reports the per-sample increment and flags illegal multi-bit transitions.
module grey_sync_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic [N-1:0] gray_in,
  input  logic         clr_err,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] step_out,
  output logic         chg_pulse,
  output logic         multi_bit_err,
  output logic [7:0]   err_cnt
);

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] PRIME_CNT = WW'(SYNC_STAGES + 1);

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit of the difference vector is set.
  function automatic logic multi_bit(input logic [N-1:0] d);
    return (d & (d - {{(N-1){1'b0}}, 1'b1})) != {N{1'b0}};
  endfunction

  logic [N-1:0]  r_sync [SYNC_STAGES];
  logic [N-1:0]  r_prev_gray;
  logic [N-1:0]  r_bin;
  logic [N-1:0]  r_step;
  logic          r_chg;
  logic          r_err;
  logic [7:0]    r_err_cnt;
  logic [WW-1:0] r_warm;

  logic [N-1:0]  w_gray_q;
  logic [N-1:0]  w_bin_now;
  logic [N-1:0]  w_bin_prev;
  logic          w_primed;
  logic          w_chg;
  logic          w_err;

  assign w_gray_q   = r_sync[SYNC_STAGES-1];
  assign w_bin_now  = gray2bin(w_gray_q);
  assign w_bin_prev = gray2bin(r_prev_gray);
  assign w_primed   = (r_warm == PRIME_CNT);
  assign w_chg      = (w_gray_q != r_prev_gray);
  assign w_err      = w_primed & multi_bit(w_gray_q ^ r_prev_gray);

  // Synchronizer, warm-up counter, decode, change/step and error tracking.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_step      <= '0;
      r_chg       <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_warm      <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev_gray <= w_gray_q;
      r_bin       <= w_bin_now;

      if (!w_primed) begin
        r_warm <= r_warm + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        r_warm <= r_warm;
      end

      // Until primed, prev_gray may still hold reset zeros, so no change is reported.
      if (w_primed) begin
        r_chg  <= w_chg;
        r_step <= w_bin_now - w_bin_prev;
      end else begin
        r_chg  <= 1'b0;
        r_step <= '0;
      end

      if (w_err) begin
        r_err <= 1'b1;
        if (clr_err) begin
          r_err_cnt <= 8'd1;
        end else if (r_err_cnt == 8'd255) begin
          r_err_cnt <= r_err_cnt;
        end else begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else if (clr_err) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else begin
        r_err     <= r_err;
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign bin_out       = r_bin;
  assign step_out      = r_step;
  assign chg_pulse     = r_chg;
  assign multi_bit_err = r_err;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_grey_sync_decoder.sv
// Directed bench for grey_sync_decoder: counting, wrap, illegal jumps, warm-up,
// error clear/saturation and mid-run reset, with hand-computed expectations.
module tb_grey_sync_decoder;

  logic       clk;
  logic       srst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic [3:0] step_out;
  logic       chg_pulse;
  logic       multi_bit_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  grey_sync_decoder #(.N(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .srst_n        (srst_n),
    .gray_in       (gray_in),
    .clr_err       (clr_err),
    .bin_out       (bin_out),
    .step_out      (step_out),
    .chg_pulse     (chg_pulse),
    .multi_bit_err (multi_bit_err),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_chg"},  {31'd0, chg_pulse}, 32'd0);
    check({tag, "_step"}, {28'd0, step_out}, 32'd0);
    check({tag, "_err"},  {31'd0, multi_bit_err}, 32'd0);
  endtask

  initial begin
    srst_n  = 1'b0;
    gray_in = 4'b0000;
    clr_err = 1'b0;
    tick(2);
    check("rst_bin",  {28'd0, bin_out}, 32'd0);
    check("rst_step", {28'd0, step_out}, 32'd0);
    check("rst_chg",  {31'd0, chg_pulse}, 32'd0);
    check("rst_err",  {31'd0, multi_bit_err}, 32'd0);
    check("rst_cnt",  {24'd0, err_cnt}, 32'd0);

    // Counting 0001 -> 0011 -> 0010
    srst_n = 1'b1;
    tick(4);
    gray_in = 4'b0001;
    tick(2);
    check("cnt1_early_bin", {28'd0, bin_out}, 32'd0);
    tick(1);
    check("cnt1_bin",  {28'd0, bin_out}, 32'd1);
    check("cnt1_step", {28'd0, step_out}, 32'd1);
    check("cnt1_chg",  {31'd0, chg_pulse}, 32'd1);
    tick(1);
    check("cnt1_hold_chg",  {31'd0, chg_pulse}, 32'd0);
    check("cnt1_hold_step", {28'd0, step_out}, 32'd0);
    check("cnt1_hold_bin",  {28'd0, bin_out}, 32'd1);
    gray_in = 4'b0011;
    tick(3);
    check("cnt2_bin",  {28'd0, bin_out}, 32'd2);
    check("cnt2_step", {28'd0, step_out}, 32'd1);
    check("cnt2_chg",  {31'd0, chg_pulse}, 32'd1);
    tick(1);
    gray_in = 4'b0010;
    tick(3);
    check("cnt3_bin",  {28'd0, bin_out}, 32'd3);
    check("cnt3_step", {28'd0, step_out}, 32'd1);
    check("cnt3_chg",  {31'd0, chg_pulse}, 32'd1);
    tick(1);
    check("cnt_err", {31'd0, multi_bit_err}, 32'd0);

    // Wrap: start at bin 14 via reset, then 15 and 0
    srst_n  = 1'b0;
    gray_in = 4'b1001;
    tick(1);
    srst_n = 1'b1;
    tick(4);
    check("wrap_start_bin", {28'd0, bin_out}, 32'd14);
    check_quiet("wrap_start");
    gray_in = 4'b1000;
    tick(3);
    check("wrap15_bin",  {28'd0, bin_out}, 32'd15);
    check("wrap15_step", {28'd0, step_out}, 32'd1);
    check("wrap15_chg",  {31'd0, chg_pulse}, 32'd1);
    tick(1);
    gray_in = 4'b0000;
    tick(3);
    check("wrap0_bin",  {28'd0, bin_out}, 32'd0);
    check("wrap0_step", {28'd0, step_out}, 32'd1);
    check("wrap0_chg",  {31'd0, chg_pulse}, 32'd1);
    check("wrap0_err",  {31'd0, multi_bit_err}, 32'd0);
    tick(1);

    // Illegal jump 0000 -> 0011
    gray_in = 4'b0011;
    tick(2);
    check("jump_pre_err", {31'd0, multi_bit_err}, 32'd0);
    tick(1);
    check("jump_bin",  {28'd0, bin_out}, 32'd2);
    check("jump_step", {28'd0, step_out}, 32'd2);
    check("jump_chg",  {31'd0, chg_pulse}, 32'd1);
    check("jump_err",  {31'd0, multi_bit_err}, 32'd1);
    check("jump_cnt",  {24'd0, err_cnt}, 32'd1);
    tick(3);
    check("jump_hold_err", {31'd0, multi_bit_err}, 32'd1);
    check("jump_hold_cnt", {24'd0, err_cnt}, 32'd1);
    check("jump_hold_chg", {31'd0, chg_pulse}, 32'd0);

    // Warm-up: 0110 held through reset
    srst_n  = 1'b0;
    gray_in = 4'b0110;
    tick(1);
    check("warm_rst_cnt", {24'd0, err_cnt}, 32'd0);
    srst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_quiet("warm");
      check("warm_bin", {28'd0, bin_out}, (i >= 3) ? 32'd4 : 32'd0);
    end

    // Saturation: 300 alternating jumps (0110 -> 0000 is itself a 2-bit jump)
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick(1);
    end
    tick(4);
    check("sat_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_err", {31'd0, multi_bit_err}, 32'd1);

    // Clear with no coinciding error
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err", {31'd0, multi_bit_err}, 32'd0);
    check("clr_cnt", {24'd0, err_cnt}, 32'd0);

    // Clear on the same edge as a new jump (0011 -> 0000)
    gray_in = 4'b0000;
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_race_err", {31'd0, multi_bit_err}, 32'd1);
    check("clr_race_cnt", {24'd0, err_cnt}, 32'd1);
    tick(2);

    // Four more jumps to reach err_cnt 5, then a legal move to bin 7
    for (int i = 0; i < 4; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      tick(1);
    end
    gray_in = 4'b0100;
    tick(4);
    check("mid_pre_bin", {28'd0, bin_out}, 32'd7);
    check("mid_pre_cnt", {24'd0, err_cnt}, 32'd5);

    // Mid-run reset for one edge
    srst_n = 1'b0;
    tick(1);
    check("mid_rst_bin",  {28'd0, bin_out}, 32'd0);
    check("mid_rst_step", {28'd0, step_out}, 32'd0);
    check("mid_rst_chg",  {31'd0, chg_pulse}, 32'd0);
    check("mid_rst_err",  {31'd0, multi_bit_err}, 32'd0);
    check("mid_rst_cnt",  {24'd0, err_cnt}, 32'd0);
    srst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_quiet("mid_warm");
      check("mid_warm_bin", {28'd0, bin_out}, (i >= 3) ? 32'd7 : 32'd0);
    end
    check("mid_final_cnt", {24'd0, err_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
